// File: rtl/key_filter_if.sv
// Key filter signal bundle: raw key in, debounced edge pulse and level out.
interface key_filter_if;
    logic key_in;
    logic key_flag;
    logic key_value;

    modport master (output key_in, input key_flag, input key_value);
    modport slave  (input key_in, output key_flag, output key_value);
endinterface

// File: rtl/key_filter.sv
// Debounces an active-low mechanical key: two-flop synchronizer feeding a
// four-state filter FSM that emits a one-cycle flag per accepted edge.
module key_filter #(
    parameter int               CNT_W   = 20,
    parameter logic [CNT_W-1:0] CNT_MAX = 20'd999_999
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    key_filter_if.slave  key_bus
);

    typedef enum logic [1:0] {IDLE, FILT_DN, DOWN, FILT_UP} state_t;

    state_t           state, state_nxt;
    logic             ff1, key_sync;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             flag_q, flag_nxt;
    logic             value_q, value_nxt;
    logic             cnt_done;

    assign cnt_done = (cnt == CNT_MAX - 1'b1);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            ff1      <= 1'b1;
            key_sync <= 1'b1;
        end else begin
            ff1      <= key_bus.key_in;
            key_sync <= ff1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!key_sync) state_nxt = FILT_DN;
            FILT_DN: if (key_sync) state_nxt = IDLE;
                     else if (cnt_done) state_nxt = DOWN;
            DOWN:    if (key_sync) state_nxt = FILT_UP;
            FILT_UP: if (!key_sync) state_nxt = DOWN;
                     else if (cnt_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Counter is zero in stable states and on every state change, so it never wraps.
    always_comb begin
        cnt_nxt   = '0;
        flag_nxt  = 1'b0;
        value_nxt = value_q;
        case (state)
            FILT_DN: if (!key_sync) begin
                if (cnt_done) begin
                    flag_nxt  = 1'b1;
                    value_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            FILT_UP: if (key_sync) begin
                if (cnt_done) begin
                    flag_nxt  = 1'b1;
                    value_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            cnt     <= '0;
            flag_q  <= 1'b0;
            value_q <= 1'b1;
        end else begin
            cnt     <= cnt_nxt;
            flag_q  <= flag_nxt;
            value_q <= value_nxt;
        end
    end

    assign key_bus.key_flag  = flag_q;
    assign key_bus.key_value = value_q;

endmodule

// File: tb/tb_key_filter.sv
// Randomized and directed checks of key_filter (CNT_MAX=10) against a run-length debounce model.
module tb_key_filter;
    localparam int CNT_MAX = 10;

    logic sys_clk = 1'b0;
    logic sys_rst_n;
    int   checks = 0;
    int   failures = 0;

    key_filter_if kif ();

    key_filter #(.CNT_W(20), .CNT_MAX(20'd10)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key_bus   (kif.slave)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference: the synchronized key must disagree with the debounced level
    // for CNT_MAX+1 consecutive samples before the level flips.
    logic m_ff1, m_sync, m_level, m_flag;
    int   m_run;
    always @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            m_ff1 <= 1'b1; m_sync <= 1'b1; m_level <= 1'b1; m_flag <= 1'b0; m_run <= 0;
        end else begin
            m_ff1  <= kif.key_in;
            m_sync <= m_ff1;
            m_flag <= 1'b0;
            if (m_sync == m_level) m_run <= 0;
            else if (m_run == CNT_MAX) begin
                m_level <= m_sync; m_flag <= 1'b1; m_run <= 0;
            end else m_run <= m_run + 1;
        end
    end

    task automatic test_reset();
        sys_rst_n = 1'b0;
        kif.key_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            checks++;
            if (kif.key_flag !== 1'b0 || kif.key_value !== 1'b1) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d flag=%b value=%b want flag=0 value=1", i, kif.key_flag, kif.key_value);
            end
        end
        sys_rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge sys_clk);
            checks++;
            if (kif.key_flag !== logic'(i == 12)) begin
                failures++;
                $display("FAIL reset_press_flag i=%0d flag=%b want %b", i, kif.key_flag, logic'(i == 12));
            end
        end
        checks++;
        if (kif.key_value !== 1'b0) begin
            failures++;
            $display("FAIL reset_press_value value=%b want 0", kif.key_value);
        end
    endtask

    task automatic test_edge(input logic lvl, input string name);
        kif.key_in = lvl;
        for (int i = 0; i < 30; i++) begin
            @(negedge sys_clk);
            checks++;
            if (kif.key_flag !== logic'(i == 12)) begin
                failures++;
                $display("FAIL %s_flag i=%0d flag=%b want %b", name, i, kif.key_flag, logic'(i == 12));
            end
            checks++;
            if (kif.key_value !== (i >= 12 ? lvl : ~lvl)) begin
                failures++;
                $display("FAIL %s_value i=%0d value=%b want %b", name, i, kif.key_value, (i >= 12 ? lvl : ~lvl));
            end
        end
    endtask

    task automatic test_bounce();
        int nflags = 0;
        kif.key_in = 1'b0;
        repeat (5) begin @(negedge sys_clk); nflags += int'(kif.key_flag); end
        kif.key_in = 1'b1;
        repeat (3) begin @(negedge sys_clk); nflags += int'(kif.key_flag); end
        checks++;
        if (nflags != 0) begin
            failures++;
            $display("FAIL bounce_early flags=%0d want 0", nflags);
        end
        kif.key_in = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk);
            checks++;
            if (kif.key_flag !== logic'(i == 12)) begin
                failures++;
                $display("FAIL bounce_flag i=%0d flag=%b want %b", i, kif.key_flag, logic'(i == 12));
            end
        end
        checks++;
        if (kif.key_value !== 1'b0) begin
            failures++;
            $display("FAIL bounce_value value=%b want 0", kif.key_value);
        end
    endtask

    task automatic test_threshold();
        int nflags = 0;
        kif.key_in = 1'b0;
        repeat (10) begin @(negedge sys_clk); nflags += int'(kif.key_flag); end
        kif.key_in = 1'b1;
        repeat (30) begin @(negedge sys_clk); nflags += int'(kif.key_flag); end
        checks++;
        if (nflags != 0 || kif.key_value !== 1'b1) begin
            failures++;
            $display("FAIL thresh_short flags=%0d value=%b want flags=0 value=1", nflags, kif.key_value);
        end
        kif.key_in = 1'b0;
        nflags = 0;
        repeat (11) begin @(negedge sys_clk); nflags += int'(kif.key_flag); end
        kif.key_in = 1'b1;
        for (int j = 0; j < 30; j++) begin
            @(negedge sys_clk);
            nflags += int'(kif.key_flag);
            checks++;
            if (kif.key_flag !== logic'(j == 1 || j == 12)) begin
                failures++;
                $display("FAIL thresh_long_flag j=%0d flag=%b want %b", j, kif.key_flag, logic'(j == 1 || j == 12));
            end
            if (j == 1) begin
                checks++;
                if (kif.key_value !== 1'b0) begin
                    failures++;
                    $display("FAIL thresh_press_value value=%b want 0", kif.key_value);
                end
            end
        end
        checks++;
        if (nflags != 2 || kif.key_value !== 1'b1) begin
            failures++;
            $display("FAIL thresh_long_total flags=%0d value=%b want flags=2 value=1", nflags, kif.key_value);
        end
    endtask

    task automatic test_reset_mid();
        kif.key_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge sys_clk);
            checks++;
            if (kif.key_flag !== 1'b0) begin
                failures++;
                $display("FAIL midrst_pre i=%0d flag=%b want 0", i, kif.key_flag);
            end
        end
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        checks++;
        if (kif.key_flag !== 1'b0 || kif.key_value !== 1'b1) begin
            failures++;
            $display("FAIL midrst_during flag=%b value=%b want flag=0 value=1", kif.key_flag, kif.key_value);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk);
            checks++;
            if (kif.key_flag !== logic'(i == 12)) begin
                failures++;
                $display("FAIL midrst_flag i=%0d flag=%b want %b", i, kif.key_flag, logic'(i == 12));
            end
        end
    endtask

    task automatic test_random();
        logic lvl = 1'b1;
        logic prev_flag = 1'b0;
        logic prev_value = kif.key_value;
        for (int seg = 0; seg < 150; seg++) begin
            lvl = ~lvl;
            kif.key_in = lvl;
            if ($urandom_range(0, 24) == 0) sys_rst_n = 1'b0;
            repeat ($urandom_range(1, 25)) begin
                @(negedge sys_clk);
                sys_rst_n = 1'b1;
                checks++;
                if (kif.key_flag !== m_flag || kif.key_value !== m_level) begin
                    failures++;
                    $display("FAIL rand_model seg=%0d flag=%b value=%b want flag=%b value=%b", seg, kif.key_flag, kif.key_value, m_flag, m_level);
                end
                checks++;
                if ((prev_flag && kif.key_flag) || (kif.key_value !== prev_value && !kif.key_flag && m_sync !== 1'b1)) begin
                    failures++;
                    $display("FAIL rand_rules seg=%0d prev_flag=%b flag=%b prev_value=%b value=%b", seg, prev_flag, kif.key_flag, prev_value, kif.key_value);
                end
                prev_flag  = kif.key_flag;
                prev_value = kif.key_value;
            end
        end
    endtask

    initial begin
        kif.key_in = 1'b1;
        sys_rst_n  = 1'b0;
        test_reset();
        test_edge(1'b1, "release");
        test_edge(1'b0, "press");
        test_edge(1'b1, "release2");
        test_bounce();
        test_edge(1'b1, "release3");
        test_threshold();
        test_reset_mid();
        test_edge(1'b1, "release4");
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end
endmodule
